// File: rtl/s5_pp_defs.sv
// Shared constants for the S5 post-processing chain: word widths,
// default collector buffer depth and von Neumann pair encodings.
package s5_pp_defs;

    localparam int S5_WORD_W     = 5;
    localparam int S5_OUT_W      = 4;
    localparam int S5_FIFO_DEPTH = 4;

    // Pair encodings as {first raw bit, second raw bit}
    localparam logic [1:0] VN_PAIR_00 = 2'b00;
    localparam logic [1:0] VN_PAIR_01 = 2'b01;
    localparam logic [1:0] VN_PAIR_10 = 2'b10;
    localparam logic [1:0] VN_PAIR_11 = 2'b11;

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock FIFO with registered occupancy, full/empty flags and a
// combinational head output; a push into a full FIFO succeeds only with a pop.
module trng_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PUSH,
    input  logic                     POP,
    input  logic [WIDTH-1:0]         WDATA,
    output logic [WIDTH-1:0]         RDATA,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   FILL
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic             w_pop;
    logic             w_push;

    assign EMPTY  = (r_fill == '0);
    assign FULL   = (r_fill == L_FULL_CNT);
    assign FILL   = r_fill;
    assign RDATA  = r_mem[r_rd_ptr];
    assign w_pop  = POP && !EMPTY;
    assign w_push = PUSH && (!FULL || w_pop);

    // Entries are reset so the head reads 0 straight after reset
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_mem[gi] <= '0;
            end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                r_mem[gi] <= WDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (AW+1)'(1);
                2'b01:   r_fill <= r_fill - (AW+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: rtl/s5_word_collector.sv
// Assembles accepted raw TRNG bits MSB-first into words and buffers them for S5.
// Optional von Neumann debiasing via S5_COLLECTOR_VON_NEUMANN_EN.
module s5_word_collector
    import s5_pp_defs::*;
#(
    parameter int WORD_W     = S5_WORD_W,
    parameter int FIFO_DEPTH = S5_FIFO_DEPTH
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BIT_IN,
    input  logic                         BIT_VALID,
    output logic [WORD_W-1:0]            D_OUT,
    output logic                         D_VALID,
    input  logic                         D_READY,
    output logic                         OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]  FILL
);

    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] L_LAST = CW'(WORD_W - 1);

    logic [CW-1:0]     r_cnt;
    logic [WORD_W-2:0] r_shift;
    logic              r_overflow;
    logic              w_acc_valid;
    logic              w_acc_bit;
    logic              w_complete;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

`ifdef S5_COLLECTOR_VON_NEUMANN_EN
    logic r_phase;
    logic r_pair;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_phase <= 1'b0;
            r_pair  <= 1'b0;
        end else if (BIT_VALID) begin
            r_phase <= ~r_phase;
            if (!r_phase) r_pair <= BIT_IN;
        end
    end

    // The decoded bit reaches the collector on the edge of the second raw bit
    always_comb begin
        w_acc_valid = 1'b0;
        w_acc_bit   = 1'b0;
        if (BIT_VALID && r_phase) begin
            case ({r_pair, BIT_IN})
                VN_PAIR_01: begin w_acc_valid = 1'b1; w_acc_bit = 1'b0; end
                VN_PAIR_10: begin w_acc_valid = 1'b1; w_acc_bit = 1'b1; end
                default:    begin w_acc_valid = 1'b0; w_acc_bit = 1'b0; end
            endcase
        end
    end
`else
    assign w_acc_valid = BIT_VALID;
    assign w_acc_bit   = BIT_IN;
`endif

    assign w_complete = w_acc_valid && (r_cnt == L_LAST);
    assign w_pop      = D_VALID && D_READY;
    assign D_VALID    = !w_empty;
    assign OVERFLOW   = r_overflow;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_acc_valid) begin
                r_cnt   <= w_complete ? '0 : r_cnt + CW'(1);
                r_shift <= w_complete ? '0 : {r_shift[WORD_W-3:0], w_acc_bit};
            end
            if (w_complete && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    trng_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (w_complete),
        .POP   (w_pop),
        .WDATA ({r_shift, w_acc_bit}),
        .RDATA (D_OUT),
        .FULL  (w_full),
        .EMPTY (w_empty),
        .FILL  (FILL)
    );

endmodule

// File: tb/tb_s5_word_collector.sv
// Directed bench for s5_word_collector with a word scoreboard and explicit checks.
module tb_s5_word_collector;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BIT_IN = 1'b0;
    logic       BIT_VALID = 1'b0;
    logic       D_READY = 1'b0;
    logic [4:0] D_OUT;
    logic       D_VALID;
    logic       OVERFLOW;
    logic [2:0] FILL;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] q[$];
    int         m_cnt = 0;
    logic [4:0] m_word = '0;
    logic       m_ovf = 1'b0;
    logic       m_phase = 1'b0;
    logic       m_pair = 1'b0;

    s5_word_collector dut (
        .CLK       (CLK),
        .RST       (RST),
        .BIT_IN    (BIT_IN),
        .BIT_VALID (BIT_VALID),
        .D_OUT     (D_OUT),
        .D_VALID   (D_VALID),
        .D_READY   (D_READY),
        .OVERFLOW  (OVERFLOW),
        .FILL      (FILL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks current outputs against the model, drives one cycle, updates the model
    task automatic cycle(input logic rst, input logic bv, input logic b, input logic rdy);
        logic pop;
        logic full;
        logic av;
        logic ab;
        RST = rst; BIT_VALID = bv; BIT_IN = b; D_READY = rdy;
        chk("d_valid", 32'(D_VALID), 32'(q.size() != 0));
        if (q.size() != 0) chk("d_out", 32'(D_OUT), 32'(q[0]));
        chk("fill", 32'(FILL), 32'(q.size()));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
        if (rst) begin
            q.delete(); m_cnt = 0; m_word = '0; m_ovf = 1'b0; m_phase = 1'b0; m_pair = 1'b0;
        end else begin
            pop  = rdy && (q.size() != 0);
            full = (q.size() == 4);
            av = bv; ab = b;
`ifdef S5_COLLECTOR_VON_NEUMANN_EN
            av = 1'b0;
            if (bv) begin
                if (!m_phase) m_pair = b;
                else if (m_pair != b) begin av = 1'b1; ab = m_pair; end
                m_phase = ~m_phase;
            end
`endif
            if (pop) void'(q.pop_front());
            if (av) begin
                m_word = {m_word[3:0], ab};
                m_cnt++;
                if (m_cnt == 5) begin
                    m_cnt = 0;
                    if (!full || pop) begin
                        q.push_back(m_word);
                        $display("push word %05b (fill %0d)", m_word, q.size());
                    end else begin
                        m_ovf = 1'b1;
                        $display("drop word %05b", m_word);
                    end
                end
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic send(input logic [4:0] w, input logic rdy);
        for (int i = 4; i >= 0; i--) cycle(1'b0, 1'b1, w[i], rdy);
    endtask

    initial begin
        @(posedge CLK); #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_dout", 32'(D_OUT), 32'd0);
        chk("rst_dvalid", 32'(D_VALID), 32'd0);
        chk("rst_fill", 32'(FILL), 32'd0);
        chk("rst_ovf", 32'(OVERFLOW), 32'd0);

`ifndef S5_COLLECTOR_VON_NEUMANN_EN
        // Basic word with consumer ready
        send(5'b10110, 1'b1);
        chk("basic_valid", 32'(D_VALID), 32'd1);
        chk("basic_dout", 32'(D_OUT), 32'b10110);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_valid_gone", 32'(D_VALID), 32'd0);
        chk("basic_fill0", 32'(FILL), 32'd0);

        // Back-to-back words
        send(5'b11111, 1'b0);
        send(5'b00001, 1'b0);
        chk("b2b_fill", 32'(FILL), 32'd2);
        chk("b2b_head", 32'(D_OUT), 32'b11111);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_second", 32'(D_OUT), 32'b00001);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_empty", 32'(D_VALID), 32'd0);

        // Overflow: five words into a four-entry buffer
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 5; w++) send(5'($urandom_range(0, 31)), 1'b0);
        chk("ovf_fill", 32'(FILL), 32'd4);
        chk("ovf_flag", 32'(OVERFLOW), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_drained", 32'(D_VALID), 32'd0);
        chk("ovf_sticky", 32'(OVERFLOW), 32'd1);

        // Full buffer with a simultaneous pop on the completing edge
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) send(5'($urandom_range(0, 31)), 1'b0);
        for (int i = 4; i >= 1; i--) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        chk("fullpop_fill", 32'(FILL), 32'd4);
        chk("fullpop_ovf", 32'(OVERFLOW), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fullpop_drained", 32'(FILL), 32'd0);

        // Reset in the middle of a word
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        send(5'b01010, 1'b0);
        chk("midrst_fill", 32'(FILL), 32'd1);
        chk("midrst_head", 32'(D_OUT), 32'b01010);
        chk("midrst_ovf", 32'(OVERFLOW), 32'd0);

        // Gapped input
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        begin
            logic [4:0] g;
            g = 5'b10011;
            for (int i = 4; i >= 0; i--) begin
                cycle(1'b0, 1'b1, g[i], 1'b0);
                if (i != 0) begin
                    cycle(1'b0, 1'b0, 1'b1, 1'b0);
                    cycle(1'b0, 1'b0, 1'b1, 1'b0);
                end
            end
        end
        chk("gap_fill", 32'(FILL), 32'd1);
        chk("gap_head", 32'(D_OUT), 32'b10011);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`else
        // Von Neumann pairs 01,10,00,11,10,01,01 then 11
        begin
            logic [13:0] raw;
            raw = 14'b01_10_00_11_10_01_01;
            for (int i = 13; i >= 0; i--) cycle(1'b0, 1'b1, raw[i], 1'b0);
        end
        chk("vn_fill", 32'(FILL), 32'd1);
        chk("vn_head", 32'(D_OUT), 32'b01100);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("vn_11_fill", 32'(FILL), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/s5_word_collector.md
Name: s5_word_collector

Overview:
- Upstream neighbour of the S5 post-processing substitution stage.
- Takes the sampled ring-oscillator raw bit stream one bit at a time and assembles 5-bit words.
- Buffers completed words in a small FIFO and presents them with a valid/ready handshake to the S5 input (D_IN[4:0]).
- Decouples the bursty raw-bit arrival rate from the downstream consumer and flags lost words.

Parameters:
- WORD_W, 5, word width; must equal the S5 input width.
- FIFO_DEPTH, 4, completed-word buffer entries; power of two, at least 2.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- BIT_IN  input  1  raw TRNG sample bit.
- BIT_VALID  input  1  BIT_IN is valid this cycle; no backpressure to the sampler.
- D_OUT  output  WORD_W  assembled word; drives the S5 D_IN.
- D_VALID  output  1  D_OUT holds an unread word.
- D_READY  input  1  consumer takes D_OUT this cycle when D_VALID=1.
- OVERFLOW  output  1  sticky; set when a completed word was dropped.
- FILL  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST=1 at an edge): bit counter=0, shift register=0, FIFO empty. Outputs: D_OUT=0, D_VALID=0, OVERFLOW=0, FILL=0. Any in-progress partial word is discarded, and RST overrides all other inputs.
- Collection: each "accepted bit" is shifted in MSB-first. The first accepted bit of a word lands in D_OUT[4] and the fifth lands in D_OUT[0]. The counter runs 0..4.
- Word completion: on the edge that accepts the 5th bit, the full word (shift register concatenated with the incoming bit) is pushed to the FIFO and the counter wraps to 0 on that same edge. No bubble: a bit accepted on the next cycle starts the next word.
- Latency: if the FIFO was empty, D_VALID=1 on the cycle after the completing edge.
- Handshake:
  - A pop occurs on an edge where D_VALID=1 and D_READY=1.
  - D_OUT and D_VALID are stable while D_VALID=1 and D_READY=0.
  - D_READY is ignored when D_VALID=0.
  - D_OUT shows the FIFO head. Its value when D_VALID=0 is 0 after reset and otherwise undefined to the consumer.
- FIFO full plus a completing word:
  - With a simultaneous pop: the push is accepted and FILL is unchanged.
  - With no pop: the word is dropped, OVERFLOW is set, and FIFO contents are unchanged. The counter still wraps, so collection continues.
- Empty FIFO plus push: there is no pop that cycle, because D_VALID was 0.
- OVERFLOW clears only on RST.
- FILL is always the registered occupancy, within 0..FIFO_DEPTH.

Optional Feature:
- Macro: S5_COLLECTOR_VON_NEUMANN_EN.
- With the macro defined:
  - BIT_VALID bits are first paired by a von Neumann debiaser. A one-bit pair register plus a phase flag hold the first bit of each pair.
  - Pair 01 yields accepted bit 0; pair 10 yields accepted bit 1; pairs 00 and 11 yield nothing.
  - The accepted bit is presented to the collector on the same edge as the second raw bit.
  - RST clears both the phase flag and the pair register.
- Without the macro: every BIT_VALID bit is an accepted bit.

Decomposition:
- Shared package / header file s5_pp_defs holds:
  - S5_WORD_W=5 and S5_OUT_W=4;
  - the default FIFO_DEPTH;
  - the von Neumann pair encodings.
- One sub-module: trng_sync_fifo. It is a single-clock FIFO with registered FILL, full/empty flags and a head output, parameterised by width and depth, and reusable by the downstream 4-bit packer.
- The bit collector and the debiaser stay in the top module.

Test Plan:
- Basic word: after reset, bits 1,0,1,1,0 on consecutive cycles with D_READY=1 → D_VALID=1 for exactly one cycle, starting one cycle after the 5th bit, with D_OUT=5'b10110; FILL returns to 0.
- Back-to-back words: 10 contiguous bits 1,1,1,1,1 then 0,0,0,0,1 with D_READY=0 → FILL=2 and head=5'b11111; raising D_READY gives 5'b11111 then 5'b00001 on consecutive cycles.
- Overflow: D_READY=0 and 25 bits (5 words) → FILL=4, OVERFLOW=1 after the 25th bit, and the 5th word is absent on drain. Repeat with D_READY=1 on the completing cycle → no overflow and FILL stays 4.
- Reset mid-word: 3 bits, then RST, then bits 0,1,0,1,0 → a single word 5'b01010; OVERFLOW=0 and FILL=1.
- Gapped input: 5 bits 1,0,0,1,1 with BIT_VALID low for 2 cycles between each bit → D_OUT=5'b10011, unaffected by the gaps.
- With S5_COLLECTOR_VON_NEUMANN_EN: raw pairs 01,10,00,11,10,01,01 → one word 5'b01100; the following raw pair 11 produces no word and FILL stays 1.
